// File: rtl/flu_wb_arbiter_if.sv
// flu_wb_arbiter_if: producer/writeback bus of the FLU writeback merger.
//   Producer side : flush_i, ch_valid_i/ch_ready_o, ch_result_i, ch_trans_id_i, ch_exc_i
//   Writeback side: wb_valid_o/wb_ready_i, wb_result_o, wb_trans_id_o, wb_exc_o, wb_ch_o
//   Status        : busy_o
// Signal suffixes are from the arbiter's point of view (slave modport).
interface flu_wb_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned TID_W  = 3,
  parameter int unsigned EXC_W  = 129
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                      flush_i;
  logic [NUM_CH-1:0]         ch_valid_i;
  logic [NUM_CH-1:0]         ch_ready_o;
  logic [NUM_CH*XLEN-1:0]    ch_result_i;
  logic [NUM_CH*TID_W-1:0]   ch_trans_id_i;
  logic [NUM_CH*EXC_W-1:0]   ch_exc_i;
  logic                      wb_valid_o;
  logic                      wb_ready_i;
  logic [XLEN-1:0]           wb_result_o;
  logic [TID_W-1:0]          wb_trans_id_o;
  logic [EXC_W-1:0]          wb_exc_o;
  logic [CH_W-1:0]           wb_ch_o;
  logic                      busy_o;

  // Arbiter side
  modport slave (
    input  flush_i, ch_valid_i, ch_result_i, ch_trans_id_i, ch_exc_i, wb_ready_i,
    output ch_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_exc_o, wb_ch_o, busy_o
  );

  // Producers + scoreboard side
  modport master (
    output flush_i, ch_valid_i, ch_result_i, ch_trans_id_i, ch_exc_i, wb_ready_i,
    input  ch_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_exc_o, wb_ch_o, busy_o
  );
endinterface

// File: rtl/flu_wb_arbiter.sv
// flu_wb_arbiter: merges NUM_CH fixed-latency-unit result channels onto one
// scoreboard writeback port. Each channel owns a DEPTH-entry result queue;
// queue heads are arbitrated round-robin (RR_ARB=1) or fixed priority
// (RR_ARB=0, ch0 highest). A stalled grant is locked until its handshake.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   bus (slave)     producer channels, writeback port, flush, busy
// Optional feature macro FLU_WB_PERF_EN adds:
//   perf_clr_i      synchronous clear of the stall counters
//   stall_cnt_o     NUM_CH x 32-bit saturating "valid while not ready" counters
module flu_wb_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned TID_W  = 3,
  parameter int unsigned EXC_W  = 129,
  parameter bit          RR_ARB = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
`ifdef FLU_WB_PERF_EN
  input  logic                    perf_clr_i,
  output logic [NUM_CH*32-1:0]    stall_cnt_o,
`endif
  flu_wb_arbiter_if.slave         bus
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [EXC_W-1:0] exc;
    logic [TID_W-1:0] tid;
    logic [XLEN-1:0]  result;
  } entry_t;

  entry_t           mem_q    [NUM_CH][DEPTH];
  entry_t           mem_d    [NUM_CH][DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] cnt_d    [NUM_CH];
  logic             lock_q, lock_d;
  logic [CH_W-1:0]  lock_idx_q, lock_idx_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_CH-1:0] ready_c;
  logic [NUM_CH-1:0] nonempty_c;
  logic [NUM_CH-1:0] push_c;
  logic [CH_W-1:0]   arb_idx_c;
  logic [CH_W-1:0]   grant_c;
  logic              wb_valid_c;
  logic              hs_c;
  entry_t            head_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Queue status: ready depends on occupancy only, never on wb_ready_i
  always_comb begin
    ready_c    = '0;
    nonempty_c = '0;
    push_c     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ready_c[CH_W'(i)]    = (cnt_q[CH_W'(i)] < CNT_W'(DEPTH));
      nonempty_c[CH_W'(i)] = (cnt_q[CH_W'(i)] != '0);
      push_c[CH_W'(i)]     = bus.ch_valid_i[CH_W'(i)] & ready_c[CH_W'(i)];
    end
  end

  // Arbitration: first non-empty channel from the RR pointer (or from ch0)
  always_comb begin
    int unsigned cand;
    logic        found;
    arb_idx_c = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = (RR_ARB ? 32'(rr_ptr_q) : 32'd0) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!found && nonempty_c[CH_W'(cand)]) begin
        found     = 1'b1;
        arb_idx_c = CH_W'(cand);
      end
    end
  end

  // A stalled grant stays put until it handshakes
  assign grant_c    = lock_q ? lock_idx_q : arb_idx_c;
  assign wb_valid_c = |nonempty_c;
  assign hs_c       = wb_valid_c & bus.wb_ready_i;
  assign head_c     = mem_q[grant_c][rd_ptr_q[grant_c]];

  assign bus.ch_ready_o    = ready_c;
  assign bus.wb_valid_o    = wb_valid_c;
  assign bus.busy_o        = wb_valid_c;
  assign bus.wb_result_o   = wb_valid_c ? head_c.result : '0;
  assign bus.wb_trans_id_o = wb_valid_c ? head_c.tid    : '0;
  assign bus.wb_exc_o      = wb_valid_c ? head_c.exc    : '0;
  assign bus.wb_ch_o       = wb_valid_c ? grant_c       : '0;

  // Next-state: queue push/pop, lock and RR pointer; flush discards everything
  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;

    if (bus.flush_i) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        rd_ptr_d[CH_W'(i)] = '0;
        wr_ptr_d[CH_W'(i)] = '0;
        cnt_d[CH_W'(i)]    = '0;
      end
      lock_d     = 1'b0;
      lock_idx_d = '0;
      rr_ptr_d   = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        logic pop;
        pop = hs_c && (grant_c == CH_W'(i));
        if (push_c[CH_W'(i)]) begin
          mem_d[CH_W'(i)][wr_ptr_q[CH_W'(i)]] = '{
            exc:    bus.ch_exc_i[i*EXC_W +: EXC_W],
            tid:    bus.ch_trans_id_i[i*TID_W +: TID_W],
            result: bus.ch_result_i[i*XLEN +: XLEN]
          };
          wr_ptr_d[CH_W'(i)] = ptr_inc(wr_ptr_q[CH_W'(i)]);
        end
        if (pop) rd_ptr_d[CH_W'(i)] = ptr_inc(rd_ptr_q[CH_W'(i)]);
        case ({push_c[CH_W'(i)], pop})
          2'b10:   cnt_d[CH_W'(i)] = cnt_q[CH_W'(i)] + CNT_W'(1);
          2'b01:   cnt_d[CH_W'(i)] = cnt_q[CH_W'(i)] - CNT_W'(1);
          default: cnt_d[CH_W'(i)] = cnt_q[CH_W'(i)];
        endcase
      end
      lock_d     = wb_valid_c & ~bus.wb_ready_i;
      lock_idx_d = grant_c;
      if (hs_c) begin
        rr_ptr_d = (grant_c == CH_W'(NUM_CH - 1)) ? '0 : grant_c + CH_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
          mem_q[CH_W'(i)][PTR_W'(j)] <= '0;
        end
        rd_ptr_q[CH_W'(i)] <= '0;
        wr_ptr_q[CH_W'(i)] <= '0;
        cnt_q[CH_W'(i)]    <= '0;
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef FLU_WB_PERF_EN
  logic [31:0] stall_cnt_q [NUM_CH];
  logic [31:0] stall_cnt_d [NUM_CH];

  // Saturating per-channel backpressure counters; untouched by flush
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (perf_clr_i) begin
        stall_cnt_d[CH_W'(i)] = '0;
      end else if (bus.ch_valid_i[CH_W'(i)] && !ready_c[CH_W'(i)] &&
                   (stall_cnt_q[CH_W'(i)] != '1)) begin
        stall_cnt_d[CH_W'(i)] = stall_cnt_q[CH_W'(i)] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_CH; i++) stall_cnt_q[CH_W'(i)] <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) stall_cnt_o[i*32 +: 32] = stall_cnt_q[CH_W'(i)];
  end
`endif

endmodule

// File: tb/tb_flu_wb_arbiter.sv
// Scoreboard bench for flu_wb_arbiter: a queue-based reference model predicts
// the writeback port each cycle; a monitor compares DUT outputs against it.
module tb_flu_wb_arbiter;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned TID_W  = 3;
  localparam int unsigned EXC_W  = 129;
  localparam bit          RR_ARB = 1'b1;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  flu_wb_arbiter_if #(.NUM_CH(NUM_CH), .XLEN(XLEN), .TID_W(TID_W), .EXC_W(EXC_W)) bus ();

`ifdef FLU_WB_PERF_EN
  logic                     perf_clr_i;
  logic [NUM_CH*32-1:0]     stall_cnt_o;
`endif

  flu_wb_arbiter #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .XLEN(XLEN), .TID_W(TID_W), .EXC_W(EXC_W), .RR_ARB(RR_ARB)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
`ifdef FLU_WB_PERF_EN
    .perf_clr_i  (perf_clr_i),
    .stall_cnt_o (stall_cnt_o),
`endif
    .bus         (bus)
  );

  typedef struct {
    logic [XLEN-1:0]  r;
    logic [TID_W-1:0] t;
    logic [EXC_W-1:0] e;
  } ent_t;

  typedef struct {
    bit                v;
    int                ch;
    ent_t              d;
    logic [NUM_CH-1:0] rdy;
  } exp_t;

  // Reference model state
  ent_t  mq [NUM_CH][$];
  int    m_rr;
  bit    m_lock;
  int    m_lch;
  longint m_stall [NUM_CH];

  exp_t  exp_q [$];
  ent_t  d_ent [NUM_CH];
  int    checks;
  int    passed;
  bit    drv_done;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endfunction

  function automatic ent_t rand_ent();
    ent_t x;
    logic [159:0] w;
    w   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    x.r = {$urandom, $urandom};
    x.t = TID_W'($urandom);
    x.e = w[EXC_W-1:0];
    return x;
  endfunction

  // Channel the spec's arbitration rules select from the current model state, -1 if none
  function automatic int model_grant();
    if (m_lock) return m_lch;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      int c;
      c = RR_ARB ? (m_rr + k) % int'(NUM_CH) : k;
      if (mq[c].size() > 0) return c;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs, publish the expected output, then advance the model
  task automatic step(input logic [NUM_CH-1:0] vmask, input bit rdy, input bit fl, input bit keep);
    exp_t e;
    int   g;
    int   pre [NUM_CH];
    @(negedge clk_i);
    if (!keep) for (int c = 0; c < int'(NUM_CH); c++) d_ent[c] = rand_ent();
    bus.ch_valid_i = vmask;
    bus.wb_ready_i = rdy;
    bus.flush_i    = fl;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      bus.ch_result_i[c*XLEN +: XLEN]     = d_ent[c].r;
      bus.ch_trans_id_i[c*TID_W +: TID_W] = d_ent[c].t;
      bus.ch_exc_i[c*EXC_W +: EXC_W]      = d_ent[c].e;
    end
    g    = model_grant();
    e.v  = (g >= 0);
    e.ch = e.v ? g : 0;
    e.d  = e.v ? mq[g][0] : '{r: '0, t: '0, e: '0};
    for (int c = 0; c < int'(NUM_CH); c++) begin
      pre[c]   = mq[c].size();
      e.rdy[c] = (pre[c] < int'(DEPTH));
    end
    exp_q.push_back(e);
    @(posedge clk_i);
    for (int c = 0; c < int'(NUM_CH); c++) if (vmask[c] && pre[c] >= int'(DEPTH)) m_stall[c]++;
    if (fl) begin
      for (int c = 0; c < int'(NUM_CH); c++) mq[c].delete();
      m_lock = 0;
      m_rr   = 0;
    end else begin
      if (e.v && rdy) begin
        void'(mq[g].pop_front());
        m_rr = (g + 1) % int'(NUM_CH);
      end
      for (int c = 0; c < int'(NUM_CH); c++)
        if (vmask[c] && pre[c] < int'(DEPTH)) mq[c].push_back(d_ent[c]);
      m_lock = e.v && !rdy;
      m_lch  = g;
    end
  endtask

  task automatic driver();
    for (int i = 0; i < 10; i++) step('0, 1'b1, 1'b0, 1'b0);
    // Single push on ch2 with fixed payload
    for (int c = 0; c < int'(NUM_CH); c++) d_ent[c] = rand_ent();
    d_ent[2].r = 64'hDEAD;
    d_ent[2].t = 3'd5;
    step(4'b0100, 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    // All channels at once, two rounds
    for (int r = 0; r < 2; r++) begin
      step(4'b1111, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step('0, 1'b1, 1'b0, 1'b0);
    end
    // Stalled ch1 grant must not be overtaken by ch0
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    // ch3 overfill, drain, refill across the pointer wrap
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step('0, 1'b1, 1'b0, 1'b0);
    // Fill queues, then flush together with a push on ch0 and a blocked ch3
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    step(4'b1001, 1'b0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    // Random traffic
    for (int i = 0; i < 3000; i++)
      step(NUM_CH'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0), 1'b0);
    step('0, 1'b1, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    drv_done = 1'b1;
  endtask

  task automatic monitor();
    int idle;
    exp_t e;
    idle = 0;
    while (!(drv_done && exp_q.size() == 0)) begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() == 0) begin
        idle++;
        if (idle > 2000) begin
          chk("monitor_timeout", 256'(idle), 256'(0));
          break;
        end
      end else begin
        idle = 0;
        e = exp_q.pop_front();
        chk("wb_valid", 256'(bus.wb_valid_o), 256'(e.v));
        chk("busy", 256'(bus.busy_o), 256'(e.v));
        chk("ch_ready", 256'(bus.ch_ready_o), 256'(e.rdy));
        chk("wb_result", 256'(bus.wb_result_o), 256'(e.d.r));
        chk("wb_trans_id", 256'(bus.wb_trans_id_o), 256'(e.d.t));
        chk("wb_exc", 256'(bus.wb_exc_o), 256'(e.d.e));
        if (e.v) chk("wb_ch", 256'(bus.wb_ch_o), 256'(e.ch));
      end
    end
  endtask

  initial begin
    checks   = 0;
    passed   = 0;
    drv_done = 1'b0;
    m_rr     = 0;
    m_lock   = 0;
    m_lch    = 0;
    for (int c = 0; c < int'(NUM_CH); c++) m_stall[c] = 0;
    rst_ni            = 1'b0;
    bus.flush_i       = 1'b0;
    bus.ch_valid_i    = '0;
    bus.ch_result_i   = '0;
    bus.ch_trans_id_i = '0;
    bus.ch_exc_i      = '0;
    bus.wb_ready_i    = 1'b0;
`ifdef FLU_WB_PERF_EN
    perf_clr_i        = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    chk("reset_wb_valid", 256'(bus.wb_valid_o), 256'(0));
    chk("reset_ch_ready", 256'(bus.ch_ready_o), 256'(4'b1111));
    rst_ni = 1'b1;
    fork
      driver();
      monitor();
    join
    chk("scoreboard_leftover", 256'(exp_q.size()), 256'(0));
`ifdef FLU_WB_PERF_EN
    for (int c = 0; c < int'(NUM_CH); c++)
      chk($sformatf("stall_cnt%0d", c), 256'(stall_cnt_o[c*32 +: 32]), 256'(m_stall[c]));
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
